// File: rtl/lsu_byte_seq_if.sv
// Bus bundle for the load/store byte sequencer: execute-stage request/response
// plus the byte-wide data-memory port.
interface lsu_byte_seq_if #(
   parameter int AW   = 9,
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            resp_valid;
   logic [XLEN-1:0] resp_rdata;
   logic            resp_fault;
   logic            dm_read;
   logic            dm_write;
   logic [2:0]      dmop;
   logic [AW-1:0]   dm_addr;
   logic [XLEN-1:0] dm_din;
   logic [XLEN-1:0] dm_dout;

   // Core plus data memory side: drives requests and memory read data.
   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, dm_dout,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
             dm_read, dm_write, dmop, dm_addr, dm_din
   );

   // Sequencer side.
   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, dm_dout,
      output req_ready, resp_valid, resp_rdata, resp_fault,
             dm_read, dm_write, dmop, dm_addr, dm_din
   );
endinterface

// File: rtl/lsu_byte_seq.sv
// Splits one load/store request into byte-wide data-memory accesses, assembles
// load bytes little-endian, extends them and returns a single response pulse.
module lsu_byte_seq #(
   parameter int AW   = 9,
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         rst,
   lsu_byte_seq_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t          r_state;
   logic            r_req_ready;
   logic            r_resp_valid;
   logic            r_resp_fault;
   logic [XLEN-1:0] r_resp_rdata;
   logic            r_dm_read;
   logic            r_dm_write;
   logic [2:0]      r_dmop;
   logic [AW-1:0]   r_dm_addr;
   logic [XLEN-1:0] r_dm_din;
   logic            r_write;
   logic [2:0]      r_funct3;
   logic [XLEN-1:0] r_wdata;
   logic [XLEN-1:0] r_asm;
   logic [1:0]      r_cnt;
   logic [1:0]      r_last;

   logic            w_bad_funct3;
   logic            w_bad_store;
   logic            w_bad_addr;
   logic            w_fault;
   logic [1:0]      w_len_m1;
   logic [1:0]      w_next_cnt;
   logic [7:0]      w_wbyte;
   logic            w_cap_en;
   logic [1:0]      w_cap_lane;
   logic [XLEN-1:0] w_full;
   logic [XLEN-1:0] w_ext;

   assign w_bad_funct3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
   assign w_bad_store  = bus.req_write && bus.req_funct3[2];
   assign w_bad_addr   = |bus.req_addr[XLEN-1:AW];
   assign w_fault      = w_bad_funct3 || w_bad_store || w_bad_addr;

   assign w_len_m1   = (bus.req_funct3[1:0] == 2'b00) ? 2'd0 :
                       (bus.req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
   assign w_next_cnt = r_cnt + 2'd1;
   assign w_wbyte    = 8'(r_wdata >> {w_next_cnt, 3'b000});

   // Read data lags its strobe by one cycle, so lane k lands while byte k+1 issues.
   assign w_cap_en   = (r_state == S_ISSUE && !r_write && r_cnt != 2'd0) || (r_state == S_DRAIN);
   assign w_cap_lane = (r_state == S_DRAIN) ? r_last : (r_cnt - 2'd1);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_full = r_asm;
      for (int i = 0; i < 4; i++)
         if (2'(i) == r_last) w_full[8*i +: 8] = bus.dm_dout[7:0];
      w_ext = w_full;
      case (r_funct3)
         3'b000:  w_ext = {{(XLEN-8){w_full[7]}}, w_full[7:0]};
         3'b001:  w_ext = {{(XLEN-16){w_full[15]}}, w_full[15:0]};
         3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_full[7:0]};
         3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_full[15:0]};
         default: w_ext = w_full;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_fault <= 1'b0;
         r_resp_rdata <= '0;
         r_dm_read    <= 1'b0;
         r_dm_write   <= 1'b0;
         r_dmop       <= 3'b000;
         r_dm_addr    <= '0;
         r_dm_din     <= '0;
         r_write      <= 1'b0;
         r_funct3     <= 3'b000;
         r_wdata      <= '0;
         r_asm        <= '0;
         r_cnt        <= 2'd0;
         r_last       <= 2'd0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_req_ready  <= 1'b0;
                  r_write      <= bus.req_write;
                  r_funct3     <= bus.req_funct3;
                  r_wdata      <= bus.req_wdata;
                  r_last       <= w_len_m1;
                  r_cnt        <= 2'd0;
                  r_asm        <= '0;
                  r_resp_rdata <= '0;
                  r_resp_fault <= w_fault;
                  if (w_fault) begin
                     r_state      <= S_DONE;
                     r_resp_valid <= 1'b1;
                  end else begin
                     r_state   <= S_ISSUE;
                     r_dm_addr <= bus.req_addr[AW-1:0];
                     if (bus.req_write) begin
                        r_dm_write <= 1'b1;
                        r_dm_din   <= {{(XLEN-8){1'b0}}, bus.req_wdata[7:0]};
                     end else begin
                        r_dm_read <= 1'b1;
                        r_dmop    <= 3'b100;
                     end
                  end
               end
            end
            S_ISSUE: begin
               if (r_cnt == r_last) begin
                  r_dm_read  <= 1'b0;
                  r_dm_write <= 1'b0;
                  r_dmop     <= 3'b000;
                  r_dm_din   <= '0;
                  if (r_write) begin
                     r_state      <= S_DONE;
                     r_resp_valid <= 1'b1;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end else begin
                  r_cnt     <= w_next_cnt;
                  r_dm_addr <= r_dm_addr + AW'(1);
                  if (r_write) r_dm_din <= {{(XLEN-8){1'b0}}, w_wbyte};
               end
            end
            S_DRAIN: begin
               r_state      <= S_DONE;
               r_resp_valid <= 1'b1;
               r_resp_rdata <= w_ext;
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
         if (w_cap_en)
            for (int i = 0; i < 4; i++)
               if (2'(i) == w_cap_lane) r_asm[8*i +: 8] <= bus.dm_dout[7:0];
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.resp_fault = r_resp_fault;
   assign bus.dm_read    = r_dm_read;
   assign bus.dm_write   = r_dm_write;
   assign bus.dmop       = r_dmop;
   assign bus.dm_addr    = r_dm_addr;
   assign bus.dm_din     = r_dm_din;

endmodule

// File: doc/lsu_byte_seq.md
Name: lsu_byte_seq

Overview:
- Load/store sequencer sitting directly upstream of the byte-addressed data memory (DM) in the single-cycle CPU datapath.
- Accepts one load/store request from the execute stage and splits it into byte-wide DM accesses, so any alignment is supported.
- Assembles load bytes little-endian, applies sign/zero extension, and returns a single response pulse; the core stalls while req_ready is low.
- Uses only DM byte ops: dmop 3'b000 for writes, 3'b100 for reads.

Parameters:
- AW, 9, DM byte-address width; DM holds 2^AW bytes.
- XLEN, 32, data/request address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; request accepted on an edge with req_valid&req_ready.
- req_write  input  1  1=store, 0=load.
- req_funct3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data; low bytes are used.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  XLEN  extended load data; 0 for stores and faults.
- resp_fault  output  1  valid with resp_valid; request was rejected.
- dm_read  output  1  DM read strobe.
- dm_write  output  1  DM write strobe.
- dmop  output  3  3'b100 while reading, 3'b000 otherwise.
- dm_addr  output  AW  DM byte address.
- dm_din  output  XLEN  {24'b0, current store byte}.
- dm_dout  input  XLEN  DM read data; bits [7:0] are valid the cycle after a dm_read cycle (DM output is registered).

Behaviour:
- Reset (async): state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_fault=0; dm_read=0, dm_write=0; dmop=0, dm_addr=0, dm_din=0; byte counter and assembly register = 0.
- States:
  - IDLE: go to ISSUE on accept; go to DONE on accept with a fault.
  - ISSUE: one byte per cycle, k=0..N-1.
  - DRAIN (loads only): captures the last byte.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE.
- N = 1/2/4 for funct3[1:0] = 00/01/10.
- Request fields are latched at the accept edge; later input changes are ignored.
- Fault conditions, decided at accept (state goes directly to DONE with resp_fault=1, resp_rdata=0, no DM strobes):
  - funct3 011, 110 or 111;
  - store with funct3 100 or 101;
  - req_addr[XLEN-1:AW] != 0.
- Byte addressing: dm_addr = (base + k) mod 2^AW. Wrap past 0x1FF to 0x000 is legal; there is no alignment requirement.
- Cycle numbering: cycle 1 is the first cycle after the accept edge.
- Store timing:
  - cycles 1..N: dm_write=1, dm_din[7:0]=wdata[8k+7:8k];
  - cycle N+1: DONE;
  - cycle N+2: req_ready=1.
- Load timing:
  - cycles 1..N: dm_read=1;
  - cycles 2..N+1: byte k-1 captured from dm_dout[7:0] into lane k-1;
  - cycle N+1 is DRAIN; cycle N+2 is DONE.
- Load extension: signed ops extend bit 8N-1; bu/hu zero-extend; lw returns the raw 32 bits.
- Throughput: back-to-back requests have one IDLE cycle between them. req_valid outside IDLE is ignored (not queued).
- Reset mid-operation: strobes drop immediately and state returns to IDLE. Store bytes already written stay written; no response is generated.
- dm_read and dm_write are never high in the same cycle, and both are 0 outside ISSUE.

Test Plan:
- sw 0xDEADBEEF at 0x010 -> dm_write high cycles 1..4, addresses 0x010..0x013, bytes EF,BE,AD,DE; resp_valid in cycle 5, fault=0.
- After that store: lw 0x010 -> resp_rdata=0xDEADBEEF in cycle 6. lb 0x013 -> 0xFFFFFFDE. lbu 0x013 -> 0x000000DE. lh 0x012 -> 0xFFFFDEAD.
- Misaligned/wrap: sh 0xA55A at 0x1FF -> bytes 5A@0x1FF, A5@0x000. lhu 0x1FF -> 0x0000A55A. lh 0x1FF -> 0xFFFFA55A.
- Faults: lw 0x200, sb with funct3=101, funct3=011 -> resp_valid+resp_fault in cycle 1, resp_rdata=0, no dm strobe ever.
- Reset mid-sw (0x11223344 at 0x020, rst asserted in cycle 3) -> strobes drop asynchronously, state=IDLE, no resp. Then lw 0x020 -> low two bytes 0x3344, upper bytes unchanged from their prior contents.
- Busy handling: req_valid held high with a second request during a load -> second request accepted only in the IDLE cycle after DONE; first response is unaffected.
